flow_ctrl_fsm_p: RTL and testbench
==================================

Name: flow_ctrl_fsm_p

Overview:
Parametrised flow-control state machine for an NCH-channel FIFO bank. It watches per-channel status flags and produces per-channel pause, continue and sticky full-error controls, plus a global idle flag. Compared with the fixed-width controller, it adds:
- level-held pause with hysteresis;
- debounced idle entry;
- software error clear.

It sits between the FIFO bank and the arbiter/source logic.

Parameters:
NCH, 4, number of FIFO channels monitored and controlled.
IDLE_CYCLES, 3, consecutive all-empty cycles required in ACTIVE before entering IDLE (>=1).
ERR_CNT_W, 8, width of the error-entry counter (only used with FLOW_ERR_COUNT_EN).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
enb  in  1  when low, state, counters and outputs hold.
iniciar  in  1  start request; leaves INIT.
err_clr  in  1  error clear request; leaves ERROR.
almost_full  in  NCH  per-channel almost-full flag.
full  in  NCH  per-channel full flag.
almost_empty  in  NCH  per-channel almost-empty flag.
empty  in  NCH  per-channel empty flag.
pausa  out  NCH  per-channel stop-writing request.
continuar  out  NCH  per-channel stop-reading (low-water) indication.
error_full  out  NCH  sticky per-channel overflow record.
idle  out  1  bank idle.
state_o  out  6  one-hot current state, for debug and bench.
err_cnt  out  ERR_CNT_W  error entries (only with FLOW_ERR_COUNT_EN).

Behaviour:
- Encoding: one-hot, states RESET=0, INIT=1, IDLE=2, ACTIVE=3, PAUSE=4, ERROR=5. Exactly one state_o bit is high at any time.
- Reset: rst=1 at a posedge forces RESET and sets pausa, continuar, error_full, idle and the idle counter to 0, regardless of enb. rst dominates every other input.
- Output timing: all outputs are registered and computed from the next state and the inputs sampled at the same edge, giving 1-cycle latency from input to output.
- Transitions (evaluated only when enb=1):
  - RESET -> INIT when rst=0.
  - INIT -> IDLE when iniciar=1; otherwise stay.
  - IDLE -> ERROR if |full; else -> ACTIVE if ~&empty; else stay.
  - ACTIVE, in priority order: |full -> ERROR; |almost_full -> PAUSE; all-empty counter reaches IDLE_CYCLES -> IDLE; otherwise stay.
  - PAUSE: |full -> ERROR; almost_full==0 -> ACTIVE; otherwise stay.
  - ERROR: err_clr=1 and full==0 -> INIT; otherwise stay. err_clr while any full is high is ignored.
- All-empty counter:
  - Width $clog2(IDLE_CYCLES+1).
  - Increments each ACTIVE cycle with &empty; clears on any non-empty cycle or when leaving ACTIVE.
  - Saturates at IDLE_CYCLES.
- Outputs by next state:
  - idle = 1 in IDLE, else 0.
  - pausa is cleared on entry to PAUSE, then loaded with almost_full and OR-accumulated each PAUSE cycle. It is held until exit and is 0 in every other state.
  - continuar = almost_empty & ~empty in ACTIVE and PAUSE, else 0.
  - error_full accumulates |= full while in ERROR. It is cleared only by the ERROR -> INIT transition or by rst.
- Boundary cases:
  - full and almost_full asserted in the same cycle: ERROR wins.
  - empty and almost_empty asserted together: continuar bit = 0.
  - enb low mid-PAUSE: pausa is held unchanged.
  - rst during ERROR: error_full clears.

Optional Feature:
FLOW_ERR_COUNT_EN.
- Defined: the err_cnt port exists. It increments by 1 on every entry to ERROR, saturates at all-ones, and is cleared only by rst (err_clr does not clear it).
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package flow_ctrl_pkg holds:
  - state index constants (RESET..ERROR);
  - NUM_STATES=6;
  - the default parameter values.
- One sub-module is natural: flow_sat_cnt (parametrised saturating counter with clear and increment). It is used for both the all-empty counter and err_cnt.

Test Plan (NCH=4, IDLE_CYCLES=3):
- Reset then start: rst 2 cycles, iniciar=1, empty=4'hF -> state_o INIT then IDLE; idle=1; all other outputs 0.
- Debounced idle: in ACTIVE, hold empty=4'hF for 3 cycles -> IDLE entered on the 3rd edge. Same test with a 1-cycle gap at cycle 2 -> still ACTIVE after 3 cycles.
- Pause hysteresis: almost_full=4'b0010 for 1 cycle, then 4'b1000 for 2 cycles, then 0 -> pausa 0010, 1010, 1010, then 0000 with ACTIVE on exit.
- Full priority: full=4'b0100 with almost_full=4'b1111 simultaneously -> ERROR; error_full=0100; pausa=0.
- Error clear: in ERROR, err_clr=1 with full=4'b0100 -> stay in ERROR. Then full=0 with err_clr=1 -> INIT and error_full=0. With FLOW_ERR_COUNT_EN, err_cnt=1 after first entry and stays 1 after clear.
- Continue and enb: almost_empty=4'b0011, empty=4'b0001 in ACTIVE -> continuar=0010. Then enb=0 with inputs changed -> outputs and state_o frozen.

Source files
------------

// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control FSM: state indices, one-hot
// state type and default parameter values.
package flow_ctrl_pkg;

  localparam int S_RESET  = 0;
  localparam int S_INIT   = 1;
  localparam int S_IDLE   = 2;
  localparam int S_ACTIVE = 3;
  localparam int S_PAUSE  = 4;
  localparam int S_ERROR  = 5;

  localparam int NUM_STATES = 6;

  localparam int NCH_DEF         = 4;
  localparam int IDLE_CYCLES_DEF = 3;
  localparam int ERR_CNT_W_DEF   = 8;

  typedef enum logic [NUM_STATES-1:0] {
    ST_RESET  = NUM_STATES'(1 << S_RESET),
    ST_INIT   = NUM_STATES'(1 << S_INIT),
    ST_IDLE   = NUM_STATES'(1 << S_IDLE),
    ST_ACTIVE = NUM_STATES'(1 << S_ACTIVE),
    ST_PAUSE  = NUM_STATES'(1 << S_PAUSE),
    ST_ERROR  = NUM_STATES'(1 << S_ERROR)
  } state_e;

endpackage

// File: rtl/flow_ctrl_fsm_p_sat_cnt.sv
// flow_sat_cnt: saturating up-counter with synchronous clear and enable.
// Used for the all-empty debounce counter and the error-entry counter.
module flow_sat_cnt #(
  parameter int           W   = 2,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise increment until MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register; reset overrides enable
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/flow_ctrl_fsm_p.sv
// Flow-control FSM for an NCH-channel FIFO bank.
// Optional macro FLOW_ERR_COUNT_EN adds the err_cnt port (ERROR entry count).
//
// state  | meaning
// RESET  | held in reset, all controls low
// INIT   | waiting for iniciar
// IDLE   | bank idle, waiting for data or overflow
// ACTIVE | normal flow, debouncing all-empty towards IDLE
// PAUSE  | writers paused, pausa accumulates almost_full
// ERROR  | overflow seen, error_full sticky until err_clr with no full
module flow_ctrl_fsm_p
  import flow_ctrl_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  iniciar,
  input  logic                  err_clr,
  input  logic [NCH-1:0]        almost_full,
  input  logic [NCH-1:0]        full,
  input  logic [NCH-1:0]        almost_empty,
  input  logic [NCH-1:0]        empty,
  output logic [NCH-1:0]        pausa,
  output logic [NCH-1:0]        continuar,
  output logic [NCH-1:0]        error_full,
  output logic                  idle,
  output logic [NUM_STATES-1:0] state_o
`ifdef FLOW_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  localparam int             ECW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [ECW-1:0] IDLE_LAST = ECW'(IDLE_CYCLES - 1);

  state_e         state_q, state_d;
  logic [NCH-1:0] pausa_q, pausa_d;
  logic [NCH-1:0] continuar_q, continuar_d;
  logic [NCH-1:0] error_full_q, error_full_d;
  logic           idle_q, idle_d;
  logic [ECW-1:0] ecnt;
  logic           all_empty;
  logic           ecnt_inc, ecnt_clr;

  assign all_empty = &empty;

  // next state and next registered outputs, derived from the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (iniciar) state_d = ST_IDLE;
      ST_IDLE: begin
        if (|full)           state_d = ST_ERROR;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|full)                                  state_d = ST_ERROR;
        else if (|almost_full)                      state_d = ST_PAUSE;
        else if (all_empty && (ecnt >= IDLE_LAST))  state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (|full)              state_d = ST_ERROR;
        else if (~|almost_full) state_d = ST_ACTIVE;
      end
      ST_ERROR: if (err_clr && ~|full) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase

    idle_d = (state_d == ST_IDLE);

    pausa_d = '0;
    if (state_d == ST_PAUSE) begin
      pausa_d = (state_q == ST_PAUSE) ? (pausa_q | almost_full) : almost_full;
    end

    continuar_d = '0;
    if ((state_d == ST_ACTIVE) || (state_d == ST_PAUSE)) begin
      continuar_d = almost_empty & ~empty;
    end

    error_full_d = error_full_q;
    if (state_d == ST_ERROR) begin
      error_full_d = error_full_q | full;
    end else if (state_q == ST_ERROR) begin
      error_full_d = '0;
    end

    ecnt_inc = (state_q == ST_ACTIVE) && all_empty;
    ecnt_clr = (state_q != ST_ACTIVE) || !all_empty || (state_d != ST_ACTIVE);
  end

  // state and output registers; hold while enb is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      pausa_q      <= '0;
      continuar_q  <= '0;
      error_full_q <= '0;
      idle_q       <= 1'b0;
    end else if (enb) begin
      state_q      <= state_d;
      pausa_q      <= pausa_d;
      continuar_q  <= continuar_d;
      error_full_q <= error_full_d;
      idle_q       <= idle_d;
    end
  end

  flow_sat_cnt #(
    .W   (ECW),
    .MAX (ECW'(IDLE_CYCLES))
  ) u_empty_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (enb),
    .clr   (ecnt_clr),
    .inc   (ecnt_inc),
    .cnt_o (ecnt)
  );

`ifdef FLOW_ERR_COUNT_EN
  flow_sat_cnt #(
    .W   (ERR_CNT_W),
    .MAX ({ERR_CNT_W{1'b1}})
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (enb),
    .clr   (1'b0),
    .inc   ((state_d == ST_ERROR) && (state_q != ST_ERROR)),
    .cnt_o (err_cnt)
  );
`else
  // keeps ERR_CNT_W referenced in builds without the error counter
  logic [ERR_CNT_W-1:0] err_cnt_unused;
  assign err_cnt_unused = '0;
`endif

  assign pausa      = pausa_q;
  assign continuar  = continuar_q;
  assign error_full = error_full_q;
  assign idle       = idle_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_flow_ctrl_fsm_p.sv
// Directed-vector bench for flow_ctrl_fsm_p (NCH=4, IDLE_CYCLES=3).
// Honours FLOW_ERR_COUNT_EN when defined.
module tb_flow_ctrl_fsm_p;

  localparam int NCH = 4;
  localparam int ECW = 8;

  localparam logic [5:0] SR = 6'h01;
  localparam logic [5:0] SI = 6'h02;
  localparam logic [5:0] SD = 6'h04;
  localparam logic [5:0] SA = 6'h08;
  localparam logic [5:0] SP = 6'h10;
  localparam logic [5:0] SE = 6'h20;

  typedef struct {
    logic       rst, enb, ini, clr;
    logic [3:0] af, fu, ae, em;
    logic [5:0] st;
    logic [3:0] pa, co, ef;
    logic       idl;
    logic [7:0] ec;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, enb, iniciar, err_clr;
  logic [NCH-1:0] almost_full, full, almost_empty, empty;
  logic [NCH-1:0] pausa, continuar, error_full;
  logic           idle;
  logic [5:0]     state_o;
`ifdef FLOW_ERR_COUNT_EN
  logic [ECW-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int vec_no   = 0;

  flow_ctrl_fsm_p #(.NCH(NCH), .IDLE_CYCLES(3), .ERR_CNT_W(ECW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .iniciar      (iniciar),
    .err_clr      (err_clr),
    .almost_full  (almost_full),
    .full         (full),
    .almost_empty (almost_empty),
    .empty        (empty),
    .pausa        (pausa),
    .continuar    (continuar),
    .error_full   (error_full),
    .idle         (idle),
    .state_o      (state_o)
`ifdef FLOW_ERR_COUNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic e, input logic i, input logic c,
                             input logic [3:0] af, input logic [3:0] fu,
                             input logic [3:0] ae, input logic [3:0] em,
                             input logic [5:0] st, input logic [3:0] pa,
                             input logic [3:0] co, input logic [3:0] ef,
                             input logic idl, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.enb = e; t.ini = i; t.clr = c;
    t.af = af; t.fu = fu; t.ae = ae; t.em = em;
    t.st = st; t.pa = pa; t.co = co; t.ef = ef; t.idl = idl; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, vec_no, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; enb = t.enb; iniciar = t.ini; err_clr = t.clr;
    almost_full = t.af; full = t.fu; almost_empty = t.ae; empty = t.em;
    @(posedge clk);
    #1;
    chk("state_o",    state_o,    t.st);
    chk("pausa",      pausa,      t.pa);
    chk("continuar",  continuar,  t.co);
    chk("error_full", error_full, t.ef);
    chk("idle",       idle,       t.idl);
    chk("onehot",     $onehot(state_o), 1);
`ifdef FLOW_ERR_COUNT_EN
    chk("err_cnt",    err_cnt,    t.ec);
`endif
    vec_no++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; enb = 1'b1; iniciar = 1'b0; err_clr = 1'b0;
    almost_full = '0; full = '0; almost_empty = '0; empty = 4'hF;

    //                 rst enb ini clr  af    full  ae    empty   st  pa    co    ef    idl ec
    // reset then start
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SR, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SR, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SI, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SD, 4'h0, 4'h0, 4'h0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SD, 4'h0, 4'h0, 4'h0, 1, 0));
    // debounced idle: three all-empty cycles
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SD, 4'h0, 4'h0, 4'h0, 1, 0));
    // gap at cycle 2 restarts the debounce
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    // pause hysteresis
    tbl.push_back(v(0, 1, 0, 0, 4'h2, 4'h0, 4'h0, 4'hE,  SP, 4'h2, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h8, 4'h0, 4'h0, 4'hE,  SP, 4'hA, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h8, 4'h0, 4'h0, 4'hE,  SP, 4'hA, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    // continuar, including empty+almost_empty on channel 0, then enb freeze
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1,  SA, 4'h0, 4'h2, 4'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'hF, 4'h4, 4'hF, 4'h0,  SA, 4'h0, 4'h2, 4'h0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 4'hF, 4'h4, 4'hF, 4'h0,  SA, 4'h0, 4'h2, 4'h0, 0, 0));
    // enb low mid-PAUSE holds pausa
    tbl.push_back(v(0, 1, 0, 0, 4'h4, 4'h0, 4'h0, 4'hE,  SP, 4'h4, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SP, 4'h4, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h1, 4'h0, 4'h0, 4'hE,  SP, 4'h5, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SA, 4'h0, 4'h0, 4'h0, 0, 0));
    // full beats almost_full; error clear blocked while full
    tbl.push_back(v(0, 1, 0, 0, 4'hF, 4'h4, 4'hF, 4'hE,  SE, 4'h0, 4'h0, 4'h4, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 4'h0, 4'h4, 4'h0, 4'hE,  SE, 4'h0, 4'h0, 4'h4, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h1, 4'h0, 4'hE,  SE, 4'h0, 4'h0, 4'h5, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE,  SE, 4'h0, 4'h0, 4'h5, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 4'hE,  SI, 4'h0, 4'h0, 4'h0, 0, 1));
    // second error entry from IDLE, then rst during ERROR (with enb low)
    tbl.push_back(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SD, 4'h0, 4'h0, 4'h0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'hF,  SE, 4'h0, 4'h0, 4'h2, 0, 2));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h2, 4'h0, 4'hF,  SR, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF,  SI, 4'h0, 4'h0, 4'h0, 0, 0));

    #2;
    foreach (tbl[i]) apply(tbl[i]);

    // enb low in INIT ignores iniciar for several cycles
    for (int k = 0; k < 3; k++)
      apply(v(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF, SI, 4'h0, 4'h0, 4'h0, 0, 0));
    apply(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF, SD, 4'h0, 4'h0, 4'h0, 1, 0));

    // rst with enb low clears continuar from ACTIVE
    apply(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hE, SA, 4'h0, 4'h0, 4'h0, 0, 0));
    apply(v(0, 1, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0, SA, 4'h0, 4'hF, 4'h0, 0, 0));
    apply(v(1, 0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0, SR, 4'h0, 4'h0, 4'h0, 0, 0));

    // almost_full held in PAUSE keeps pausa; exit directly to ERROR clears it
    apply(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF, SI, 4'h0, 4'h0, 4'h0, 0, 0));
    apply(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF, SD, 4'h0, 4'h0, 4'h0, 1, 0));
    apply(v(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h7, SA, 4'h0, 4'h0, 4'h0, 0, 0));
    apply(v(0, 1, 0, 0, 4'h9, 4'h0, 4'h8, 4'h7, SP, 4'h9, 4'h8, 4'h0, 0, 0));
    apply(v(0, 1, 0, 0, 4'h9, 4'h0, 4'h8, 4'h7, SP, 4'h9, 4'h8, 4'h0, 0, 0));
    apply(v(0, 1, 0, 0, 4'h9, 4'h8, 4'h8, 4'h7, SE, 4'h0, 4'h0, 4'h8, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
